// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (see mem_arb_pick).
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_D  = 1'b1;

   localparam int unsigned TO_W = 8;
   typedef logic [TO_W-1:0] cnt_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational grant selection between fetch and data requests.
// MEM_ARB_ROUND_ROBIN_EN: alternate on contention; otherwise data always wins.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic d_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic last_grant,
`endif
   output logic valid,
   output logic gnt
);

   always_comb begin
      valid = if_req | d_req;
      gnt   = GNT_D;
      if (if_req && !d_req) begin
         gnt = GNT_IF;
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      else if (if_req && d_req) begin
         gnt = (last_grant == GNT_D) ? GNT_IF : GNT_D;
      end
`endif
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter and sequencer for a single-port memory.
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin instead of data priority.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack
);

   state_t            state, state_n;
   cnt_t              cnt, cnt_n;
   logic              gnt, gnt_n;
   logic              pick_valid, pick_gnt;
   logic              timeout_hit;
   logic              mem_req_n, mem_we_n, if_ack_n, d_ack_n, err_n;
   logic [ADDR_W-1:0] mem_addr_n;
   logic [DATA_W-1:0] mem_wdata_n, if_rdata_n, d_rdata_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic              last_grant, last_grant_n;
`endif

   mem_arb_pick u_pick (
      .if_req     (if_req),
      .d_req      (d_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .last_grant (last_grant),
`endif
      .valid      (pick_valid),
      .gnt        (pick_gnt)
   );

   // cnt holds the number of completed BUSY cycles, so TIMEOUT-1 marks the last one
   assign timeout_hit = (cnt == cnt_t'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (pick_valid) state_n = BUSY;
         BUSY:    if (mem_ack || timeout_hit) state_n = DONE;
         DONE:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Next values of the registered outputs; ack/rdata/err are single-cycle
   always_comb begin
      gnt_n       = gnt;
      cnt_n       = cnt;
      mem_req_n   = (state_n == BUSY);
      mem_we_n    = mem_we;
      mem_addr_n  = mem_addr;
      mem_wdata_n = mem_wdata;
      if_ack_n    = 1'b0;
      d_ack_n     = 1'b0;
      err_n       = 1'b0;
      if_rdata_n  = '0;
      d_rdata_n   = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      last_grant_n = last_grant;
`endif
      case (state)
         IDLE: begin
            if (pick_valid) begin
               gnt_n = pick_gnt;
               cnt_n = '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
               last_grant_n = pick_gnt;
`endif
               if (pick_gnt == GNT_D) begin
                  mem_we_n    = d_we;
                  mem_addr_n  = d_addr;
                  mem_wdata_n = d_wdata;
               end else begin
                  mem_we_n    = 1'b0;
                  mem_addr_n  = if_addr;
                  mem_wdata_n = '0;
               end
            end
         end
         BUSY: begin
            if (mem_ack) begin
               if (gnt == GNT_IF) begin
                  if_ack_n   = 1'b1;
                  if_rdata_n = mem_rdata;
               end else begin
                  d_ack_n    = 1'b1;
                  d_rdata_n  = mem_rdata;
               end
            end else if (timeout_hit) begin
               err_n = 1'b1;
               if (gnt == GNT_IF) begin
                  if_ack_n = 1'b1;
               end else begin
                  d_ack_n  = 1'b1;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         gnt       <= GNT_IF;
         cnt       <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         if_ack    <= 1'b0;
         d_ack     <= 1'b0;
         err       <= 1'b0;
         if_rdata  <= '0;
         d_rdata   <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant <= GNT_D;
`endif
      end else begin
         gnt       <= gnt_n;
         cnt       <= cnt_n;
         mem_req   <= mem_req_n;
         mem_we    <= mem_we_n;
         mem_addr  <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         if_ack    <= if_ack_n;
         d_ack     <= d_ack_n;
         err       <= err_n;
         if_rdata  <= if_rdata_n;
         d_rdata   <= d_rdata_n;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_grant <= last_grant_n;
`endif
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT shortened to 6).
// Contention expectations follow MEM_ARB_ROUND_ROBIN_EN when it is defined.
module tb_mem_arbiter;

   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned TO = 6;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req, d_req, d_we, mem_ack;
   logic [AW-1:0] if_addr, d_addr;
   logic [DW-1:0] d_wdata, mem_rdata;
   logic [DW-1:0] if_rdata, d_rdata, mem_wdata;
   logic [AW-1:0] mem_addr;
   logic          if_ack, d_ack, err, mem_req, mem_we;

   int unsigned checks = 0;
   int unsigned errors = 0;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_rdata  (if_rdata),
      .if_ack    (if_ack),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      logic          exp_d;
      logic [DW-1:0] rd;

      rst = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
      step(); step();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_if_ack", if_ack, 0);
      chk("rst_d_ack", d_ack, 0);
      chk("rst_err", err, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata", {if_rdata, d_rdata}, 0);
      rst = 1'b1;
      step();

      // Lone fetch, memory acks in the second mem_req cycle
      if_req = 1'b1; if_addr = 32'h100;
      step();
      chk("f_mem_req", mem_req, 1);
      chk("f_mem_we", mem_we, 0);
      chk("f_mem_addr", mem_addr, 32'h100);
      step();
      chk("f_no_early_ack", if_ack, 0);
      mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
      step();
      mem_ack = 1'b0; mem_rdata = '0;
      chk("f_if_ack", if_ack, 1);
      chk("f_if_rdata", if_rdata, 32'hDEADBEEF);
      chk("f_d_ack", d_ack, 0);
      chk("f_err", err, 0);
      chk("f_mem_req_done", mem_req, 0);
      if_req = 1'b0;
      step();
      chk("f_ack_pulse", if_ack, 0);
      chk("f_rdata_clr", if_rdata, 0);

      // Store, zero-wait memory
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h200; d_wdata = 32'h12345678;
      step();
      chk("s_mem_req", mem_req, 1);
      chk("s_mem_we", mem_we, 1);
      chk("s_mem_addr", mem_addr, 32'h200);
      chk("s_mem_wdata", mem_wdata, 32'h12345678);
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
      chk("s_d_ack", d_ack, 1);
      chk("s_if_ack", if_ack, 0);
      d_req = 1'b0; d_we = 1'b0; d_wdata = '0;
      step();
      chk("s_ack_pulse", d_ack, 0);

      // Both requests held continuously
      if_req = 1'b1; if_addr = 32'h300; d_req = 1'b1; d_addr = 32'h400;
      for (int i = 0; i < 4; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         exp_d = (i % 2 == 1);
`else
         exp_d = (i < 2);
`endif
         rd = 32'hA000_0000 + DW'(i);
         step();
         chk("c_mem_req", mem_req, 1);
         chk("c_grant_addr", mem_addr, exp_d ? 32'h400 : 32'h300);
         mem_ack = 1'b1; mem_rdata = rd;
         step();
         mem_ack = 1'b0; mem_rdata = '0;
         chk("c_if_ack", if_ack, !exp_d);
         chk("c_d_ack", d_ack, exp_d);
         chk("c_rdata", exp_d ? d_rdata : if_rdata, rd);
         chk("c_other_rdata", exp_d ? if_rdata : d_rdata, 0);
`ifndef MEM_ARB_ROUND_ROBIN_EN
         if (i == 1) d_req = 1'b0;
`endif
         if (i == 3) begin
            if_req = 1'b0; d_req = 1'b0;
         end
         step();
      end

      // Memory never acks: abort after TO cycles of mem_req
      if_req = 1'b1; if_addr = 32'h500; mem_rdata = 32'hBAD0BAD0;
      step();
      for (int k = 0; k < int'(TO); k++) begin
         chk("t_mem_req_held", mem_req, 1);
         chk("t_no_ack", if_ack, 0);
         step();
      end
      chk("t_mem_req_drop", mem_req, 0);
      chk("t_if_ack", if_ack, 1);
      chk("t_err", err, 1);
      chk("t_rdata_zero", if_rdata, 0);
      if_req = 1'b0; mem_rdata = '0;
      step();
      chk("t_err_pulse", err, 0);
      chk("t_ack_pulse", if_ack, 0);

      // Ack in the final allowed cycle wins over the timeout
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
      step();
      for (int k = 0; k < int'(TO) - 1; k++) step();
      chk("e_mem_req_last", mem_req, 1);
      mem_ack = 1'b1; mem_rdata = 32'h55AA55AA;
      step();
      mem_ack = 1'b0; mem_rdata = '0;
      chk("e_d_ack", d_ack, 1);
      chk("e_err", err, 0);
      chk("e_d_rdata", d_rdata, 32'h55AA55AA);
      d_req = 1'b0;
      step();

      // Reset mid-BUSY drops the transaction; the held request is then served
      if_req = 1'b1; if_addr = 32'h700;
      step();
      chk("r_busy", mem_req, 1);
      rst = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
      step(); step();
      mem_ack = 1'b0; mem_rdata = '0;
      chk("r_mem_req", mem_req, 0);
      chk("r_acks", {if_ack, d_ack, err}, 0);
      chk("r_mem_addr", mem_addr, 0);
      chk("r_rdata", {if_rdata, d_rdata}, 0);
      rst = 1'b1;
      step();
      chk("r_acks_after", {if_ack, d_ack, err}, 0);
      chk("r_new_req", mem_req, 1);
      chk("r_new_addr", mem_addr, 32'h700);
      mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
      step();
      mem_ack = 1'b0; mem_rdata = '0;
      chk("r_if_ack", if_ack, 1);
      chk("r_if_rdata", if_rdata, 32'hCAFEF00D);
      if_req = 1'b0;
      step();
      chk("r_idle", mem_req, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter and transaction sequencer between the RISC `core` and a single-port memory. Instruction fetch and load/store requests arrive concurrently; the block grants one at a time, drives the memory handshake, returns read data with a one-cycle acknowledge, and aborts any transaction the memory fails to complete within a bounded time.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT`, 255, maximum cycles waiting for `mem_ack` before abort (1..255)

- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-low reset
- `if_req`  in  1  fetch request, held until `if_ack`
- `if_addr`  in  ADDR_W  fetch address
- `if_rdata`  out  DATA_W  fetch data, valid while `if_ack`
- `if_ack`  out  1  one-cycle completion pulse
- `d_req`  in  1  data request, held until `d_ack`
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  ADDR_W  data address
- `d_wdata`  in  DATA_W  store data
- `d_rdata`  out  DATA_W  load data, valid while `d_ack`
- `d_ack`  out  1  one-cycle completion pulse
- `err`  out  1  high with the ack pulse when the transaction timed out
- `mem_req`, `mem_we`  out  1  memory strobe / write enable
- `mem_addr`  out  ADDR_W;  `mem_wdata`  out  DATA_W
- `mem_rdata`  in  DATA_W;  `mem_ack`  in  1  memory completion

## Operation
- FSM states IDLE, BUSY, DONE. Reset state IDLE.
- IDLE: if any request, pick grant, latch `we`/`addr`/`wdata`, go BUSY. No request: stay.
- BUSY: `mem_*` driven from latched registers, `mem_req`=1. On `mem_ack`: capture `mem_rdata` into the granted port's rdata register, go DONE. On timeout counter reaching `TIMEOUT` with no ack: set `err`, rdata = 0, go DONE.
- DONE: granted port's ack = 1 for exactly this cycle, `mem_req`=0; requests ignored; go IDLE.
- Requesters drop `req` at the edge ending DONE; a request still high in IDLE is a new transaction.
- Fetch grant always has `mem_we`=0.
- Timeout counter 8-bit, cleared on entering BUSY, increments each BUSY cycle without ack; ack on the same cycle the counter hits `TIMEOUT` wins (no error).
- Non-granted port's ack and rdata stay 0.

## Timing
- All outputs registered; reset values: all 0.
- Request seen at IDLE edge N -> `mem_req` high cycle N+1.
- `mem_ack` sampled at edge M -> ack pulse cycle M+1; minimum request-to-ack latency 3 cycles (zero-wait memory).
- Back-to-back throughput: one transaction per 3 cycles plus memory wait.
- `rst` low at any edge: return to IDLE, all outputs 0 next cycle, in-flight transaction dropped, no ack issued.

## Configuration
- `MEM_ARB_ROUND_ROBIN_EN` defined: simultaneous requests go to the port not granted last; `last_grant` register resets to data, so first contention goes to fetch.
- Undefined: fixed priority, data beats fetch always; no `last_grant` register.
- Single request: granted immediately in both modes.

## Structure
- Package `mem_arb_pkg`: state enum (IDLE/BUSY/DONE), grant id constants `GNT_IF`=0, `GNT_D`=1, timeout counter width.
- Sub-module `mem_arb_pick`: combinational grant selection from `if_req`, `d_req`, `last_grant`; contains the macro-dependent logic.

## Test plan
- Reset: `rst`=0 for 2 cycles mid-BUSY -> `mem_req`=0, no ack, all outputs 0; next request served normally.
- Lone fetch `if_addr`=0x100, memory acks 1 cycle after `mem_req` with 0xDEADBEEF -> `if_ack` one cycle, `if_rdata`=0xDEADBEEF, `d_ack`=0.
- Store `d_addr`=0x200, `d_wdata`=0x12345678 -> `mem_we`=1, `mem_addr`/`mem_wdata` match, `d_ack` one pulse.
- Both requests held continuously -> with macro: grants alternate IF, D, IF, D; without: D served first, IF after D drops.
- Memory never acks -> `mem_req` high `TIMEOUT` cycles, then ack with `err`=1, rdata 0; ack arriving exactly at cycle `TIMEOUT` -> `err`=0.
